// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the sequential binary32 multiplier.
package fp_mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_NORM = 3'd2,
    S_RND  = 3'd3,
    S_PACK = 3'd4
  } fpm_state_t;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int MANT_W  = 24;
  localparam int PROD_W  = 48;
  localparam int EXP_W   = 10;

  // An exponent field of zero means zero or denormal; both flush to zero.
  function automatic logic is_zero_exp(input logic [31:0] v);
    return (v[30:23] == 8'd0);
  endfunction

endpackage

// File: rtl/round_mult.sv
// Rounding unit: adds one ulp to a 24-bit mantissa according to the
// selected mode, using guard/sticky/sign. Result is 25 bits so that a
// carry out of the mantissa is visible to the caller.
module round_mult #(
  parameter string round = "IEEE_near"
) (
  input  logic [23:0] i_mant,
  input  logic        i_guard,
  input  logic        i_sticky,
  input  logic        i_sign,
  output logic [24:0] o_result,
  output logic        o_inexact
);

  localparam int MODE_NEAR  = 0;
  localparam int MODE_ZERO  = 1;
  localparam int MODE_PINF  = 2;
  localparam int MODE_NINF  = 3;
  localparam int MODE_NUP   = 4;
  localparam int MODE_AWAY  = 5;

  localparam int MODE = (round == "IEEE_zero") ? MODE_ZERO :
                        (round == "IEEE_pinf") ? MODE_PINF :
                        (round == "IEEE_ninf") ? MODE_NINF :
                        (round == "near_up")   ? MODE_NUP  :
                        (round == "away_zero") ? MODE_AWAY : MODE_NEAR;

  // Decide whether to increment the mantissa by one ulp.
  function automatic logic round_up_f(input logic lsb, input logic g,
                                      input logic s, input logic sgn);
    logic up;
    case (MODE)
      MODE_ZERO: up = 1'b0;
      MODE_PINF: up = ~sgn & (g | s);
      MODE_NINF: up = sgn & (g | s);
      MODE_NUP:  up = g;
      MODE_AWAY: up = g | s;
      default:   up = g & (s | lsb);
    endcase
    return up;
  endfunction

  logic w_up;

  // Combinational rounding increment.
  always_comb begin
    w_up      = round_up_f(i_mant[0], i_guard, i_sticky, i_sign);
    o_result  = {1'b0, i_mant} + {24'd0, w_up};
    o_inexact = i_guard | i_sticky;
  end

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential binary32 multiplier: 24-cycle shift-add mantissa product,
// normalise, round through round_mult, pack with overflow/underflow flags.
module fp_mult_seq
  import fp_mult_pkg::*;
#(
  parameter string ROUND = "IEEE_near"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] z,
  output logic        inexact,
  output logic        ovf,
  output logic        unf
);

  localparam logic signed [EXP_W-1:0] BIAS_S    = EXP_W'(BIAS);
  localparam logic signed [EXP_W-1:0] EXP_MAX_S = EXP_W'(EXP_MAX);
  localparam logic signed [EXP_W-1:0] EXP_ONE_S = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_ZERO_S = '0;

  // Control state
  fpm_state_t         r_state;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_z;
  logic               r_inexact;
  logic               r_ovf;
  logic               r_unf;
  logic [4:0]         r_cnt;

  // Datapath state
  logic                     r_sign;
  logic                     r_zero;
  logic signed [EXP_W-1:0]  r_exp;
  logic [MANT_W-1:0]        r_ma;
  logic [MANT_W-1:0]        r_mb;
  logic [PROD_W-1:0]        r_acc;
  logic [MANT_W-1:0]        r_mant;
  logic                     r_guard;
  logic                     r_sticky;
  logic                     r_rnd_inexact;

  logic signed [EXP_W-1:0]  w_ea;
  logic signed [EXP_W-1:0]  w_eb;
  logic signed [EXP_W-1:0]  w_exp_init;
  logic                     w_zero;
  logic [PROD_W-1:0]        w_addend;
  logic [24:0]              w_rnd_result;
  logic                     w_rnd_inexact;

  // Operand decode for the accepting edge.
  always_comb begin
    w_ea       = {2'b00, a[30:23]};
    w_eb       = {2'b00, b[30:23]};
    w_exp_init = w_ea + w_eb - BIAS_S;
    w_zero     = is_zero_exp(a) | is_zero_exp(b);
    w_addend   = {{(PROD_W-MANT_W){1'b0}}, r_mb} << r_cnt;
  end

  round_mult #(
    .round(ROUND)
  ) u_round (
    .i_mant    (r_mant),
    .i_guard   (r_guard),
    .i_sticky  (r_sticky),
    .i_sign    (r_sign),
    .o_result  (w_rnd_result),
    .o_inexact (w_rnd_inexact)
  );

  // Sequencer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_z       <= '0;
      r_inexact <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            // Zero operands skip the multiply and finish on the next edge.
            r_state <= w_zero ? S_PACK : S_MULT;
          end
        end
        S_MULT: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd23) r_state <= S_NORM;
        end
        S_NORM: r_state <= S_RND;
        S_RND:  r_state <= S_PACK;
        S_PACK: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
          if (r_zero) begin
            r_z       <= {r_sign, 31'd0};
            r_inexact <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
          end else if (r_exp >= EXP_MAX_S) begin
            r_z       <= {r_sign, 8'hFF, 23'd0};
            r_inexact <= r_rnd_inexact;
            r_ovf     <= 1'b1;
            r_unf     <= 1'b0;
          end else if (r_exp <= EXP_ZERO_S) begin
            r_z       <= {r_sign, 31'd0};
            r_inexact <= r_rnd_inexact;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b1;
          end else begin
            r_z       <= {r_sign, r_exp[7:0], r_mant[22:0]};
            r_inexact <= r_rnd_inexact;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Mantissa/exponent datapath; loaded and stepped under the sequencer state.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (start) begin
          r_sign <= a[31] ^ b[31];
          r_zero <= w_zero;
          r_exp  <= w_exp_init;
          r_ma   <= {1'b1, a[22:0]};
          r_mb   <= {1'b1, b[22:0]};
          r_acc  <= '0;
        end
      end
      S_MULT: begin
        // Multiplier shifts right so bit 0 is always multiplier bit[cnt].
        if (r_ma[0]) r_acc <= r_acc + w_addend;
        r_ma <= r_ma >> 1;
      end
      S_NORM: begin
        if (r_acc[47]) begin
          r_mant   <= r_acc[47:24];
          r_guard  <= r_acc[23];
          r_sticky <= |r_acc[22:0];
          r_exp    <= r_exp + EXP_ONE_S;
        end else begin
          r_mant   <= r_acc[46:23];
          r_guard  <= r_acc[22];
          r_sticky <= |r_acc[21:0];
        end
      end
      S_RND: begin
        r_rnd_inexact <= w_rnd_inexact;
        // A rounding carry out of the mantissa renormalises by one.
        if (w_rnd_result[24]) begin
          r_mant <= w_rnd_result[24:1];
          r_exp  <= r_exp + EXP_ONE_S;
        end else begin
          r_mant <= w_rnd_result[23:0];
        end
      end
      default: ;
    endcase
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign z       = r_z;
  assign inexact = r_inexact;
  assign ovf     = r_ovf;
  assign unf     = r_unf;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed bench for fp_mult_seq: reset, arithmetic vectors, rounding modes,
// zero path, busy-ignore, back-to-back and mid-operation reset.
module tb_fp_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, inexact, ovf, unf;
  logic [31:0] z;
  logic        busy2, done2, inexact2, ovf2, unf2;
  logic [31:0] z2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_mult_seq #(.ROUND("IEEE_near")) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .z(z), .inexact(inexact), .ovf(ovf), .unf(unf)
  );

  fp_mult_seq #(.ROUND("IEEE_zero")) dut_rz (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy2), .done(done2), .z(z2), .inexact(inexact2), .ovf(ovf2), .unf(unf2)
  );

  // Issue one operation and wait (bounded) for done; cyc = edges after E0.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, output int cyc);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #2;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (z !== 32'h0)      begin bad++; $display("FAIL reset_z got=%h exp=00000000", z); end
    total++; if (inexact !== 1'b0) begin bad++; $display("FAIL reset_inexact got=%b exp=0", inexact); end
    total++; if (ovf !== 1'b0)     begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (unf !== 1'b0)     begin bad++; $display("FAIL reset_unf got=%b exp=0", unf); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_arith();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] vz [7];
    logic [31:0] vz_rz [7];
    logic [2:0]  vf [7];   // {inexact, ovf, unf}
    logic [2:0]  vf_rz [7];
    int cyc;
    va[0]=32'h3F800000; vb[0]=32'h3F800000; vz[0]=32'h3F800000; vf[0]=3'b000; vz_rz[0]=32'h3F800000; vf_rz[0]=3'b000;
    va[1]=32'h3FC00000; vb[1]=32'hBFC00000; vz[1]=32'hC0100000; vf[1]=3'b000; vz_rz[1]=32'hC0100000; vf_rz[1]=3'b000;
    va[2]=32'hBF800000; vb[2]=32'h40000000; vz[2]=32'hC0000000; vf[2]=3'b000; vz_rz[2]=32'hC0000000; vf_rz[2]=3'b000;
    va[3]=32'h3F800001; vb[3]=32'h3F800001; vz[3]=32'h3F800002; vf[3]=3'b100; vz_rz[3]=32'h3F800002; vf_rz[3]=3'b100;
    va[4]=32'h3F800001; vb[4]=32'h3FC00001; vz[4]=32'h3FC00003; vf[4]=3'b100; vz_rz[4]=32'h3FC00002; vf_rz[4]=3'b100;
    va[5]=32'h7F000000; vb[5]=32'h7F000000; vz[5]=32'h7F800000; vf[5]=3'b010; vz_rz[5]=32'h7F800000; vf_rz[5]=3'b010;
    va[6]=32'h00800000; vb[6]=32'h00800000; vz[6]=32'h00000000; vf[6]=3'b001; vz_rz[6]=32'h00000000; vf_rz[6]=3'b001;
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], cyc);
      total++; if (cyc !== 27) begin bad++; $display("FAIL arith%0d_latency got=%0d exp=27", i, cyc); end
      total++; if (z !== vz[i]) begin bad++; $display("FAIL arith%0d_z got=%h exp=%h", i, z, vz[i]); end
      total++; if ({inexact, ovf, unf} !== vf[i])
        begin bad++; $display("FAIL arith%0d_flags got=%b exp=%b", i, {inexact, ovf, unf}, vf[i]); end
      total++; if (z2 !== vz_rz[i]) begin bad++; $display("FAIL arith%0d_rz_z got=%h exp=%h", i, z2, vz_rz[i]); end
      total++; if ({inexact2, ovf2, unf2} !== vf_rz[i])
        begin bad++; $display("FAIL arith%0d_rz_flags got=%b exp=%b", i, {inexact2, ovf2, unf2}, vf_rz[i]); end
      @(posedge clk); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL arith%0d_done_pulse got=%b exp=0", i, done); end
      total++; if (z !== vz[i]) begin bad++; $display("FAIL arith%0d_z_hold got=%h exp=%h", i, z, vz[i]); end
    end
  endtask

  task automatic test_zero_path();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] vz [3];
    int cyc;
    va[0]=32'h00000000; vb[0]=32'h40000000; vz[0]=32'h00000000;
    va[1]=32'h80000000; vb[1]=32'h40000000; vz[1]=32'h80000000;
    va[2]=32'h3F800000; vb[2]=32'h00000001; vz[2]=32'h00000000;
    // Leave the flags set beforehand so the zero path must clear them.
    run_op(32'h7F000000, 32'h7F000000, cyc);
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], cyc);
      total++; if (cyc !== 1) begin bad++; $display("FAIL zero%0d_latency got=%0d exp=1", i, cyc); end
      total++; if (z !== vz[i]) begin bad++; $display("FAIL zero%0d_z got=%h exp=%h", i, z, vz[i]); end
      total++; if ({inexact, ovf, unf} !== 3'b000)
        begin bad++; $display("FAIL zero%0d_flags got=%b exp=000", i, {inexact, ovf, unf}); end
    end
  endtask

  task automatic test_busy_ignore();
    int dcnt = 0;
    int lat = 0;
    logic [31:0] zcap = '0;
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h3FC00000; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = (i < 20); a = 32'h00000000; b = 32'h00000000;
      @(posedge clk); #1;
      if (done) begin dcnt++; zcap = z; lat = i + 1; end
    end
    start = 1'b0;
    total++; if (dcnt !== 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", dcnt); end
    total++; if (zcap !== 32'h40100000) begin bad++; $display("FAIL busy_z got=%h exp=40100000", zcap); end
    total++; if (lat !== 27) begin bad++; $display("FAIL busy_latency got=%0d exp=27", lat); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_op(32'h40000000, 32'h40000000, cyc);
    total++; if (z !== 32'h40800000) begin bad++; $display("FAIL b2b_first_z got=%h exp=40800000", z); end
    // Start presented during the done cycle.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_rise got=%b exp=1", busy); end
    cyc = 0;
    while (!done && cyc < 60) begin @(posedge clk); #1; cyc++; end
    total++; if (cyc !== 27) begin bad++; $display("FAIL b2b_latency got=%0d exp=27", cyc); end
    total++; if (z !== 32'h40400000) begin bad++; $display("FAIL b2b_second_z got=%h exp=40400000", z); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, inexact, ovf, unf} !== 5'b0)
      begin bad++; $display("FAIL midrst_ctrl got=%b exp=00000", {busy, done, inexact, ovf, unf}); end
    total++; if (z !== 32'h0) begin bad++; $display("FAIL midrst_z got=%h exp=00000000", z); end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b exp=0", done); end
    run_op(32'h40000000, 32'h40400000, cyc);
    total++; if (cyc !== 27) begin bad++; $display("FAIL midrst_latency got=%0d exp=27", cyc); end
    total++; if (z !== 32'h40C00000) begin bad++; $display("FAIL midrst_z_after got=%h exp=40C00000", z); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_zero_path();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mult_seq.md
# fp_mult_seq

- Sequential single-precision (IEEE-754 binary32) multiplier controller.
- Accepts one operand pair per start pulse and runs a 24-iteration shift-add mantissa multiply.
- Then normalises and drives the existing `round_mult` rounding unit, and packs the result with overflow/underflow flags.
- It is the area-lean alternative to a combinational multiplier and sequences the rounding datapath around it.

## Interface
- `ROUND`, default `"IEEE_near"`. Rounding mode string passed unchanged to the `round_mult` instance. Legal values: `IEEE_near`, `IEEE_zero`, `IEEE_pinf`, `IEEE_ninf`, `near_up`, `away_zero`.
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `start`  in  1  — request. Sampled only while `busy`=0 (the done cycle counts as `busy`=0).
- `a`, `b`  in  32  — operands, latched on the accepting edge.
- `busy`  out  1  — high from the accepting edge until the done cycle.
- `done`  out  1  — one-cycle pulse. `z` and the flags are valid from this cycle on.
- `z`  out  32  — product. Held until the next done.
- `inexact`  out  1  — guard|sticky at rounding. 0 on the zero path.
- `ovf`, `unf`  out  1  — overflow / underflow flags, held with `z`.

## Operation
- States: IDLE, MULT, NORM, RND, PACK.
- Reset values: state IDLE; `busy`, `done`, `z`, `inexact`, `ovf`, `unf` all 0.
- IDLE, on start:
  - Latch sign = a[31]^b[31].
  - Compute exp = a[30:23] + b[30:23] − 127 in 10-bit signed.
  - Mantissas = {1, frac}.
- Zero path: if either operand's exponent field is 0, the operand is treated as zero (denormals flush to zero). Skip to done on the next edge with z = {sign, 31'b0} and all flags 0.
- MULT: 5-bit counter runs 0..23. Each cycle, if multiplier bit[cnt] is set, add mb<<cnt into the 48-bit accumulator. Leave when cnt=23.
- NORM:
  - If P[47]=1: mant = P[47:24], guard = P[23], sticky = |P[22:0], exp+1.
  - Otherwise: mant = P[46:23], guard = P[22], sticky = |P[21:0].
- RND: register `round_mult` {result, inexact}. If result[24]=1, take mant = result[24:1] and exp+1; otherwise mant = result[23:0].
- PACK:
  - If exp ≥ 255: z = {sign, 8'hFF, 23'b0}, ovf = 1.
  - Else if exp ≤ 0: z = {sign, 31'b0}, unf = 1.
  - Otherwise: z = {sign, exp[7:0], mant[22:0]}.
  - Then assert done and return to IDLE.
- Exponent field 255 (Inf/NaN) is not special-cased. It follows normal arithmetic, so it normally overflows.
- `start` while busy is ignored and has no side effect.
- `rst_n` low in any state forces the reset values immediately. The in-flight operation is discarded.

## Timing
- Accepting edge = E0.
- Normal path: MULT occupies E1..E24, NORM at E25, RND at E26, PACK at E27. `done`=1 and `busy`=0 in the cycle after E27 (latency 27).
- Zero path: `done` in the cycle after E1 (latency 1).
- Back-to-back: a start sampled in the done cycle is accepted. `done` drops on that edge and `busy` rises.
- Flags and `z` update only on the PACK / zero-path edge. They are stable at all other times.

## Structure
- Package `fp_mult_pkg` holds:
  - state enum `fpm_state_t`.
  - BIAS = 127, EXP_MAX = 255, MANT_W = 24, PROD_W = 48, EXP_W = 10.
- One sub-module: `round_mult` (existing rounding unit), instantiated with `.round(ROUND)`.
  - Its `result`/`inexact` outputs are registered only in RND.
- Shift-add multiplier and PACK logic stay inline.

## Test plan
- 0x3F800000 × 0x3F800000, IEEE_near → z = 0x3F800000, inexact/ovf/unf = 0, done exactly 27 cycles after the start edge.
- 0x3FC00000 × 0xBFC00000 → z = 0xC0100000 (−2.25), inexact = 0. Also 0xBF800000 × 0x40000000 → 0xC0000000.
- 0x3F800001 × 0x3F800001, IEEE_near → z = 0x3F800002, inexact = 1. Repeat with ROUND = IEEE_zero → z = 0x3F800002, inexact = 1.
- 0x7F000000 × 0x7F000000 → z = 0x7F800000, ovf = 1. 0x00800000 × 0x00800000 → z = 0x00000000, unf = 1.
- 0x00000000 × 0x40000000 → z = 0x00000000, done 1 cycle after start. Start pulses during busy produce no extra done.
- Drop rst_n during MULT (cycle 10) → all outputs 0 immediately. After release, 0x40000000 × 0x40400000 → z = 0x40C00000 at latency 27.
